// File: rtl/his_bank_sched_pkg.sv
// -----------------------------------------------------------------------------
// his_pkg
// Shared types and constants for the histogram bank scheduler.
//   his_state_e  : scheduler FSM state (CLEAR sweep, event acquisition, wait
//                  for the reader to release the other bank)
//   PIX_W/ACQ_W/IN_W : widths of the pixel, acquisition and in-slot counters
//   DEF_*        : default frame geometry
// -----------------------------------------------------------------------------
package his_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACQ   = 2'd1,
        ST_WAIT  = 2'd2
    } his_state_e;

    localparam int PIX_W  = 8;
    localparam int ACQ_W  = 16;
    localparam int IN_W   = 2;
    localparam int DROP_W = 16;

    localparam int DEF_DATA_NUM  = 2;
    localparam int DEF_PIXEL_NUM = 200;
    localparam int DEF_ACQ_NUM   = 33333;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/his_bank_sched_if.sv
// -----------------------------------------------------------------------------
// his_bank_sched_if
// Bundles the event input, RAM write command, reader handshake and debug
// observation signals of the bank scheduler.
//   slave  : scheduler side (consumes events / rd_done, drives everything else)
//   master : environment side (event source, RAM, reader)
//
// Handshakes:
//   Event: an event is taken on a rising clk edge where ev_valid=1 and
//   ev_ready=1; ev_valid=1 with ev_ready=0 is a dropped event (counted in
//   drop_cnt, never retried). Reader: rd_valid=1 means bank rd_bank holds a
//   finished frame; the reader releases it with a one-cycle rd_done pulse.
// -----------------------------------------------------------------------------
interface his_bank_sched_if #(
    parameter int NB = 8
);
    import his_pkg::*;

    logic                ev_valid;
    logic [NB-1:0]       ev_bin;
    logic                ev_ready;
    logic                wr_en;
    logic                wr_clr;
    logic                wr_bank;
    logic [PIX_W-1:0]    wr_pixel;
    logic [NB-1:0]       wr_bin;
    logic                his_num;
    logic                rd_valid;
    logic                rd_bank;
    logic                rd_done;
    logic                frame_done;
    logic [DROP_W-1:0]   drop_cnt;
    his_state_e          dbg_state;
    logic [ACQ_W-1:0]    dbg_acq_cnt;

    modport slave (
        input  ev_valid, ev_bin, rd_done,
        output ev_ready, wr_en, wr_clr, wr_bank, wr_pixel, wr_bin,
               his_num, rd_valid, rd_bank, frame_done, drop_cnt,
               dbg_state, dbg_acq_cnt
    );

    modport master (
        output ev_valid, ev_bin, rd_done,
        input  ev_ready, wr_en, wr_clr, wr_bank, wr_pixel, wr_bin,
               his_num, rd_valid, rd_bank, frame_done, drop_cnt,
               dbg_state, dbg_acq_cnt
    );

endinterface

// File: rtl/his_bank_sched_cnt_chain.sv
// -----------------------------------------------------------------------------
// his_cnt_chain
// Three-stage cascaded wrap counter (inner c0 -> middle c1 -> outer c2).
// Wrap limits are run-time inputs so the same chain serves as the
// in/pixel/acquisition counter during acquisition and as the pixel x bin
// address counter during the clear sweep.
// Ports:
//   clk, res   : clock, async active-high reset
//   i_inc      : advance the cascade by one
//   i_clr      : synchronous clear of all stages (wins over i_inc)
//   i_lim0..2  : last value of each stage before it wraps to 0
//   o_c0..2    : current stage values
//   o_last     : all stages sit at their limit (the next i_inc wraps all)
// -----------------------------------------------------------------------------
module his_cnt_chain #(
    parameter int W0 = 2,
    parameter int W1 = 8,
    parameter int W2 = 16
) (
    input  logic          clk,
    input  logic          res,
    input  logic          i_inc,
    input  logic          i_clr,
    input  logic [W0-1:0] i_lim0,
    input  logic [W1-1:0] i_lim1,
    input  logic [W2-1:0] i_lim2,
    output logic [W0-1:0] o_c0,
    output logic [W1-1:0] o_c1,
    output logic [W2-1:0] o_c2,
    output logic          o_last
);

    logic [W0-1:0] r_c0;
    logic [W1-1:0] r_c1;
    logic [W2-1:0] r_c2;
    logic          w_wrap0;
    logic          w_wrap1;
    logic          w_wrap2;

    assign w_wrap0 = (r_c0 == i_lim0);
    assign w_wrap1 = (r_c1 == i_lim1);
    assign w_wrap2 = (r_c2 == i_lim2);
    assign o_last  = w_wrap0 && w_wrap1 && w_wrap2;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_c0 <= '0;
            r_c1 <= '0;
            r_c2 <= '0;
        end else if (i_clr) begin
            r_c0 <= '0;
            r_c1 <= '0;
            r_c2 <= '0;
        end else if (i_inc) begin
            if (w_wrap0) begin
                r_c0 <= '0;
                if (w_wrap1) begin
                    r_c1 <= '0;
                    r_c2 <= w_wrap2 ? '0 : r_c2 + 1'b1;
                end else begin
                    r_c1 <= r_c1 + 1'b1;
                end
            end else begin
                r_c0 <= r_c0 + 1'b1;
            end
        end
    end

    assign o_c0 = r_c0;
    assign o_c1 = r_c1;
    assign o_c2 = r_c2;

endmodule

// File: rtl/his_bank_sched.sv
// -----------------------------------------------------------------------------
// his_bank_sched
// Ping-pong bank scheduler for the histogram builder RAM. Clears the write
// bank, turns accepted TDC events into increment commands, and at the end of
// each frame swaps write and read banks, offering the finished bank to the
// reader.
// Ports:
//   clk  : clock
//   res  : asynchronous active-high reset
//   bus  : his_bank_sched_if.slave (events, RAM write command, reader
//          handshake, drop counter, debug state / acquisition count)
// -----------------------------------------------------------------------------
module his_bank_sched
    import his_pkg::*;
#(
    parameter int NB        = 8,
    parameter int DATA_NUM  = DEF_DATA_NUM,
    parameter int PIXEL_NUM = DEF_PIXEL_NUM,
    parameter int ACQ_NUM   = DEF_ACQ_NUM
) (
    input  logic              clk,
    input  logic              res,
    his_bank_sched_if.slave   bus
);

    // Inner stage counts bins during the clear sweep and slot events during
    // acquisition, so it must hold the wider of the two.
    localparam int W0 = max_int(NB, IN_W);

    localparam logic [W0-1:0]    BIN_LIM = W0'((1 << NB) - 1);
    localparam logic [W0-1:0]    IN_LIM  = W0'(DATA_NUM - 1);
    localparam logic [PIX_W-1:0] PIX_LIM = PIX_W'(PIXEL_NUM - 1);
    localparam logic [ACQ_W-1:0] ACQ_LIM = ACQ_W'(ACQ_NUM - 1);

    his_state_e         r_state;
    logic               r_ev_ready;
    logic               r_wr_en;
    logic               r_wr_clr;
    logic               r_wr_bank;
    logic [PIX_W-1:0]   r_wr_pixel;
    logic [NB-1:0]      r_wr_bin;
    logic               r_his_num;
    logic               r_rd_valid;
    logic               r_rd_bank;
    logic               r_frame_done;
    logic [DROP_W-1:0]  r_drop_cnt;

    logic               w_accept;
    logic               w_drop;
    logic               w_swap;
    logic               w_cnt_inc;
    logic [W0-1:0]      w_lim0;
    logic [ACQ_W-1:0]   w_lim2;
    logic [W0-1:0]      w_c0;
    logic [PIX_W-1:0]   w_c1;
    logic [ACQ_W-1:0]   w_c2;
    logic               w_last;

    // ev_ready is registered and only ever 1 in ACQ, so it alone gates acceptance.
    assign w_accept = bus.ev_valid && r_ev_ready;
    assign w_drop   = bus.ev_valid && !r_ev_ready;

    // Swap either on the final event of a frame (reader free or releasing in
    // the same cycle) or when the reader releases the bank while we wait.
    assign w_swap = ((r_state == ST_ACQ) && w_accept && w_last &&
                     (!r_rd_valid || bus.rd_done)) ||
                    ((r_state == ST_WAIT) && bus.rd_done);

    assign w_cnt_inc = (r_state == ST_CLEAR) || w_accept;

    // Clear sweep: bin (inner) x pixel (middle), outer stage pinned at 0.
    assign w_lim0 = (r_state == ST_CLEAR) ? BIN_LIM : IN_LIM;
    assign w_lim2 = (r_state == ST_CLEAR) ? '0 : ACQ_LIM;

    his_cnt_chain #(
        .W0 (W0),
        .W1 (PIX_W),
        .W2 (ACQ_W)
    ) u_cnt (
        .clk    (clk),
        .res    (res),
        .i_inc  (w_cnt_inc),
        .i_clr  (w_swap),
        .i_lim0 (w_lim0),
        .i_lim1 (PIX_LIM),
        .i_lim2 (w_lim2),
        .o_c0   (w_c0),
        .o_c1   (w_c1),
        .o_c2   (w_c2),
        .o_last (w_last)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state      <= ST_CLEAR;
            r_ev_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_clr     <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_wr_pixel   <= '0;
            r_wr_bin     <= '0;
            r_his_num    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end

            // Reader bank bookkeeping; a swap overrides a coincident release.
            if (w_swap) begin
                r_rd_valid   <= 1'b1;
                r_rd_bank    <= r_his_num;
                r_his_num    <= ~r_his_num;
                r_frame_done <= 1'b1;
            end else if (bus.rd_done && r_rd_valid) begin
                r_rd_valid <= 1'b0;
            end

            case (r_state)
                ST_CLEAR: begin
                    r_ev_ready <= 1'b0;
                    r_wr_en    <= 1'b1;
                    r_wr_clr   <= 1'b1;
                    r_wr_bank  <= r_his_num;
                    r_wr_pixel <= w_c1;
                    r_wr_bin   <= w_c0[NB-1:0];
                    if (w_last) begin
                        r_state <= ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    r_ev_ready <= 1'b1;
                    if (w_accept) begin
                        r_wr_en    <= 1'b1;
                        r_wr_clr   <= 1'b0;
                        r_wr_bank  <= r_his_num;
                        r_wr_pixel <= w_c1;
                        r_wr_bin   <= bus.ev_bin;
                        if (w_last) begin
                            r_ev_ready <= 1'b0;
                            r_state    <= w_swap ? ST_CLEAR : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_ev_ready <= 1'b0;
                    if (bus.rd_done) begin
                        r_state <= ST_CLEAR;
                    end
                end
                default: begin
                    r_ev_ready <= 1'b0;
                    r_state    <= ST_CLEAR;
                end
            endcase
        end
    end

    assign bus.ev_ready    = r_ev_ready;
    assign bus.wr_en       = r_wr_en;
    assign bus.wr_clr      = r_wr_clr;
    assign bus.wr_bank     = r_wr_bank;
    assign bus.wr_pixel    = r_wr_pixel;
    assign bus.wr_bin      = r_wr_bin;
    assign bus.his_num     = r_his_num;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.rd_bank     = r_rd_bank;
    assign bus.frame_done  = r_frame_done;
    assign bus.drop_cnt    = r_drop_cnt;
    assign bus.dbg_state   = r_state;
    assign bus.dbg_acq_cnt = w_c2;

endmodule

// File: doc/his_bank_sched.md
# his_bank_sched

Ping-pong bank scheduler that sequences the histogram builder RAM. It counts incoming TDC events per pixel, per RAM and per acquisition, and issues clear and increment write commands to the histogram RAM. At the end of each frame it swaps the write bank with the read bank, handing a finished histogram to the downstream data-processing stage through a valid/done handshake.

## Interface
Parameters:
- `NB`, 8: TDC bin address width.
- `DATA_NUM`, 2: events accepted per pixel slot.
- `PIXEL_NUM`, 200: pixels per RAM bank.
- `ACQ_NUM`, 33333: acquisitions per frame.

Ports:
- `clk`, in, 1: single clock.
- `res`, in, 1: asynchronous, active-high reset.
- `ev_valid`, in, 1: TDC event present.
- `ev_bin`, in, NB: bin of the event.
- `ev_ready`, out, 1: scheduler accepts events.
- `wr_en`, out, 1: RAM write command.
- `wr_clr`, out, 1: 1 means write zero, 0 means increment.
- `wr_bank`, out, 1: target bank.
- `wr_pixel`, out, 8: target pixel.
- `wr_bin`, out, NB: target bin.
- `his_num`, out, 1: current write bank.
- `rd_valid`, out, 1: bank `rd_bank` holds a finished frame.
- `rd_bank`, out, 1: bank offered to the reader.
- `rd_done`, in, 1: single-cycle pulse; the reader has released `rd_bank`.
- `frame_done`, out, 1: single-cycle pulse at the bank swap.
- `drop_cnt`, out, 16: count of events presented while `ev_ready`=0. Saturates at 0xFFFF.

## Operation
States are CLEAR, ACQ and WAIT.

- **Reset:** state CLEAR. `his_num`=0, `rd_bank`=0, `rd_valid`=0, `frame_done`=0, `wr_*`=0, `ev_ready`=0, `drop_cnt`=0, all counters 0.
- **CLEAR:** sweeps pixel 0..PIXEL_NUM-1 (outer) × bin 0..2^NB-1 (inner), one address per cycle.
  - Outputs: `wr_en`=1, `wr_clr`=1, `wr_bank`=`his_num`.
  - `ev_ready`=0.
  - After the last address, go to ACQ.
- **ACQ:** `ev_ready`=1. Each accepted event (`ev_valid`&`ev_ready`) issues `wr_en`=1, `wr_clr`=0, `wr_pixel`=pix_cnt, `wr_bin`=`ev_bin`. Counters advance as a cascade:
  - in_cnt wraps at DATA_NUM-1 and carries into pix_cnt.
  - pix_cnt wraps at PIXEL_NUM-1 and carries into acq_cnt.
  - acq_cnt reaching ACQ_NUM-1 with all carries set means frame complete.
- **Frame complete:**
  - If `rd_valid`=0, or `rd_done`=1 in the same cycle, swap:
    - `rd_bank`<=`his_num`, `rd_valid`<=1, `his_num`<=~`his_num`.
    - Pulse `frame_done`, clear all counters, go to CLEAR.
  - Otherwise go to WAIT.
- **WAIT:** `ev_ready`=0. On `rd_done`, perform the swap as above and go to CLEAR.
- **Reader handshake:**
  - `rd_done` while `rd_valid`=1 with no swap in the same cycle: `rd_valid`<=0 next cycle.
  - `rd_done` while `rd_valid`=0: ignored.
  - `rd_done` coincident with a swap: `rd_valid` stays 1 and `rd_bank` now points at the new bank.
- **Drops:** `ev_valid`=1 while `ev_ready`=0 increments `drop_cnt`. The event is discarded and the counters do not move.
- **Reset mid-operation:** aborts everything immediately. The next frame starts with a full clear of bank 0.

## Timing
- All outputs are registered.
- `wr_*` appear 1 cycle after the accepting edge.
- The first CLEAR write is on the first edge after `res` deasserts.
- CLEAR lasts exactly PIXEL_NUM·2^NB cycles. `ev_ready` rises on the cycle after the last clear write.
- `frame_done`, the `his_num` toggle and the `rd_valid` rise all happen on the same edge, 1 cycle after the final event is accepted.
- Back-to-back events are accepted every cycle in ACQ, with no bubbles at pixel or acquisition wrap.
- WAIT→CLEAR takes 1 cycle after `rd_done`.

## Structure
- Shared package `his_pkg`:
  - State enum (CLEAR, ACQ, WAIT).
  - Width constants: `PIX_W`=8, `ACQ_W`=16, `IN_W`=2.
  - Defaults for `DATA_NUM`, `PIXEL_NUM` and `ACQ_NUM`.
- Sub-module `his_cnt_chain`: the cascaded in/pix/acq counter.
  - Inputs: `inc`, `clr`.
  - Outputs: count values and a `last` flag.
  - It is reused for the CLEAR sweep as a pixel×bin counter.

## Test plan
Bench parameters for all scenarios: NB=2, DATA_NUM=2, PIXEL_NUM=3, ACQ_NUM=2.

- **Reset, then release:** 12 clear writes (pixels 0..2 × bins 0..3, bank 0). `ev_ready` rises on cycle 13.
- **Full frame with the reader idle:** 12 events with bins 0,1,2,3,… give 12 increments, `wr_pixel` sequence 0,0,1,1,2,2,0,0,1,1,2,2. Then `frame_done`, `rd_valid`=1, `rd_bank`=0, `his_num`=1, followed by 12 clear writes to bank 1.
- **Second frame completes before `rd_done`:** enters WAIT with `ev_ready`=0. Three events offered there give `drop_cnt`=3. `rd_done` then gives a swap with `rd_bank`=1 and `his_num`=0.
- **`rd_done` in the same cycle as the final event:** immediate swap, no WAIT, `rd_valid` stays 1.
- **`res` asserted mid-ACQ (pixel 1):** all outputs return to their reset values. After release, bank 0 is cleared again and `drop_cnt`=0.
- **`rd_done` with `rd_valid`=0:** no state change.
